// File: rtl/seq_gen_pkg.sv
// Shared definitions for the serial pattern generator.
//   - One-hot state encodings and the FSM state type.
//   - clog2 / cnt_width helpers for sizing counters from parameters.
package seq_gen_pkg;

  localparam logic [2:0] S_IDLE  = 3'b001;
  localparam logic [2:0] S_SHIFT = 3'b010;
  localparam logic [2:0] S_GAP   = 3'b100;

  typedef enum logic [2:0] {
    ST_IDLE  = S_IDLE,
    ST_SHIFT = S_SHIFT,
    ST_GAP   = S_GAP
  } state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

  // Counter width that never collapses to zero bits (e.g. a GAP=0 build).
  function automatic int cnt_width(input int value);
    return (clog2(value) < 1) ? 1 : clog2(value);
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Command / serial-output bundle of seq_pattern_gen.
// Handshake: a command transfers on a rising clk edge where start_vld and
// start_rdy are both high; pattern and rep are sampled on that edge.
// start_vld may be asserted at any time. A command is accepted only on a
// cycle where start_rdy is high; while start_rdy is low the request is
// ignored and is not queued.
//   master: start_vld, pattern, rep, abort -> ; <- start_rdy, dout, dout_vld, sof, eof, busy
//   slave : mirror of master
interface seq_pattern_gen_if #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 8
);
  logic             start_vld;
  logic             start_rdy;
  logic [PAT_W-1:0] pattern;
  logic [CNT_W-1:0] rep;
  logic             abort;
  logic             dout;
  logic             dout_vld;
  logic             sof;
  logic             eof;
  logic             busy;

  modport master (
    output start_vld, pattern, rep, abort,
    input  start_rdy, dout, dout_vld, sof, eof, busy
  );

  modport slave (
    input  start_vld, pattern, rep, abort,
    output start_rdy, dout, dout_vld, sof, eof, busy
  );
endinterface

// File: rtl/seq_piso_shift.sv
// Parallel-load, MSB-first shift register with bit counter.
//   clk, rst_n   : clock, async active-low reset
//   clear_i      : refill with FILL and zero the bit counter
//   load_i       : load data_i, bit counter to 0 (priority over shift_i)
//   shift_i      : shift left by one, FILL enters at the LSB
//   data_i       : parallel load value
//   ser_o        : current serial bit (register MSB, directly from a flop)
//   empty_o      : ser_o is the final pattern bit; the next shift empties it
//   pre_empty_o  : ser_o is the second-to-last pattern bit
module seq_piso_shift
  import seq_gen_pkg::*;
#(
  parameter int   PAT_W = 4,
  parameter logic FILL  = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [PAT_W-1:0] data_i,
  output logic             ser_o,
  output logic             empty_o,
  output logic             pre_empty_o
);
  localparam int BIT_W = cnt_width(PAT_W);

  logic [PAT_W-1:0] sr_q, sr_d;
  logic [BIT_W-1:0] cnt_q, cnt_d;

  assign ser_o       = sr_q[PAT_W-1];
  assign empty_o     = (cnt_q == BIT_W'(PAT_W - 1));
  assign pre_empty_o = (cnt_q == BIT_W'(PAT_W - 2));

  always_comb begin
    sr_d  = sr_q;
    cnt_d = cnt_q;
    if (clear_i) begin
      sr_d  = {PAT_W{FILL}};
      cnt_d = '0;
    end else if (load_i) begin
      sr_d  = data_i;
      cnt_d = '0;
    end else if (shift_i) begin
      // Shifting in FILL leaves the idle level on ser_o once drained.
      sr_d  = {sr_q[PAT_W-2:0], FILL};
      cnt_d = empty_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr_q  <= {PAT_W{FILL}};
      cnt_q <= '0;
    end else begin
      sr_q  <= sr_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/seq_pattern_gen.sv
// Serial pattern transmitter: sends a captured PAT_W-bit pattern MSB-first,
// max(rep,1) times, with GAP idle cycles between repetitions.
//   clk, rst_n   : clock, async active-low reset
//   bus (slave)  : start_vld/start_rdy handshake, pattern, rep, abort in;
//                  dout, dout_vld, sof, eof, busy out (all registered)
//   dbg_state_o  : current FSM state
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int   PAT_W    = 4,
  parameter int   CNT_W    = 8,
  parameter int   GAP      = 0,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_pattern_gen_if.slave bus,
  output state_e          dbg_state_o
);
  localparam int GAP_W = cnt_width(GAP + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;   // repetitions left after the current one
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic             dout_vld_q, sof_q, eof_q, busy_q, rdy_q;
  logic             sof_d, eof_d;
  logic             hs;
  logic             sr_clear, sr_load, sr_shift;
  logic [PAT_W-1:0] sr_data;
  logic             sr_ser, sr_empty, sr_pre_empty;

  assign hs = bus.start_vld & rdy_q & ~bus.abort;

  seq_piso_shift #(.PAT_W(PAT_W), .FILL(IDLE_BIT)) u_shift (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (sr_clear),
    .load_i      (sr_load),
    .shift_i     (sr_shift),
    .data_i      (sr_data),
    .ser_o       (sr_ser),
    .empty_o     (sr_empty),
    .pre_empty_o (sr_pre_empty)
  );

  always_comb begin
    state_d   = state_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pat_d     = pat_q;
    sof_d     = 1'b0;
    eof_d     = 1'b0;
    sr_clear  = 1'b0;
    sr_load   = 1'b0;
    sr_shift  = 1'b0;
    sr_data   = pat_q;
    case (state_q)
      ST_IDLE: begin
        if (hs) begin
          state_d   = ST_SHIFT;
          pat_d     = bus.pattern;
          rep_cnt_d = (bus.rep == '0) ? '0 : bus.rep - 1'b1;
          sr_load   = 1'b1;
          sr_data   = bus.pattern;
          sof_d     = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (sr_empty) begin
          if (rep_cnt_q == '0) begin
            state_d  = ST_IDLE;
            sr_shift = 1'b1;      // drain so dout falls back to IDLE_BIT
          end else begin
            rep_cnt_d = rep_cnt_q - 1'b1;
            if (GAP == 0) begin
              sr_load = 1'b1;     // seamless reload from the captured copy
              sof_d   = 1'b1;
            end else begin
              state_d   = ST_GAP;
              gap_cnt_d = '0;
              sr_shift  = 1'b1;
            end
          end
        end else begin
          sr_shift = 1'b1;
          // Next bit is bit 0 of the final repetition.
          eof_d    = sr_pre_empty && (rep_cnt_q == '0);
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(GAP - 1)) begin
          state_d   = ST_SHIFT;
          gap_cnt_d = '0;
          sr_load   = 1'b1;
          sof_d     = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort overrides everything outside IDLE; in IDLE it only blocks hs.
    if (bus.abort && (state_q != ST_IDLE)) begin
      state_d   = ST_IDLE;
      rep_cnt_d = '0;
      gap_cnt_d = '0;
      sr_clear  = 1'b1;
      sr_load   = 1'b0;
      sr_shift  = 1'b0;
      sof_d     = 1'b0;
      eof_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rep_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      pat_q      <= '0;
      dout_vld_q <= 1'b0;
      sof_q      <= 1'b0;
      eof_q      <= 1'b0;
      busy_q     <= 1'b0;
      rdy_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      rep_cnt_q  <= rep_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      pat_q      <= pat_d;
      dout_vld_q <= (state_d == ST_SHIFT);
      sof_q      <= sof_d;
      eof_q      <= eof_d;
      busy_q     <= (state_d != ST_IDLE);
      rdy_q      <= (state_d == ST_IDLE);
    end
  end

  assign bus.dout      = sr_ser;
  assign bus.dout_vld  = dout_vld_q;
  assign bus.sof       = sof_q;
  assign bus.eof       = eof_q;
  assign bus.busy      = busy_q;
  assign bus.start_rdy = rdy_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_seq_pattern_gen.sv
module tb_seq_pattern_gen;
  import seq_gen_pkg::*;

  localparam int   PAT_W    = 4;
  localparam int   CNT_W    = 8;
  localparam logic IDLE_BIT = 1'b0;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic             start_vld = 1'b0;
  logic             abort = 1'b0;
  logic [PAT_W-1:0] pattern = '0;
  logic [CNT_W-1:0] rep = '0;

  seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) if0 ();
  seq_pattern_gen_if #(.PAT_W(PAT_W), .CNT_W(CNT_W)) if2 ();

  assign if0.start_vld = start_vld;
  assign if0.abort     = abort;
  assign if0.pattern   = pattern;
  assign if0.rep       = rep;
  assign if2.start_vld = start_vld;
  assign if2.abort     = abort;
  assign if2.pattern   = pattern;
  assign if2.rep       = rep;

  state_e st0, st2;

  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(0), .IDLE_BIT(IDLE_BIT)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0), .dbg_state_o(st0));
  seq_pattern_gen #(.PAT_W(PAT_W), .CNT_W(CNT_W), .GAP(2), .IDLE_BIT(IDLE_BIT)) dut2 (
    .clk(clk), .rst_n(rst_n), .bus(if2), .dbg_state_o(st2));

  // ---------------- scoreboard ----------------
  // One entry per busy cycle: {dout, dout_vld, sof, eof}. Empty queue = idle.
  logic [3:0] exp_q0[$];
  logic [3:0] exp_q2[$];
  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_stream(input int sel, input logic [PAT_W-1:0] pat, input logic [CNT_W-1:0] r);
    int n;
    int gap;
    logic [3:0] e;
    n   = (r == 0) ? 1 : int'(r);
    gap = (sel == 0) ? 0 : 2;
    for (int k = 0; k < n; k++) begin
      for (int b = PAT_W - 1; b >= 0; b--) begin
        e = {pat[b], 1'b1, (b == PAT_W - 1), ((k == n - 1) && (b == 0))};
        if (sel == 0) exp_q0.push_back(e); else exp_q2.push_back(e);
      end
      if (k < n - 1)
        for (int g = 0; g < gap; g++) begin
          e = {IDLE_BIT, 3'b000};
          if (sel == 0) exp_q0.push_back(e); else exp_q2.push_back(e);
        end
    end
  endtask

  task automatic model_step(input int sel);
    int sz;
    sz = (sel == 0) ? exp_q0.size() : exp_q2.size();
    if (sz != 0) begin
      if (abort) begin
        if (sel == 0) exp_q0.delete(); else exp_q2.delete();
      end else begin
        if (sel == 0) void'(exp_q0.pop_front()); else void'(exp_q2.pop_front());
      end
    end else if (start_vld && !abort) begin
      push_stream(sel, pattern, rep);
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      exp_q0.delete();
      exp_q2.delete();
    end else begin
      model_step(0);
      model_step(2);
    end
  end

  always @(negedge rst_n) begin
    exp_q0.delete();
    exp_q2.delete();
  end

  // {dout, dout_vld, sof, eof, busy, start_rdy, state_is_idle}
  function automatic logic [6:0] expect_vec(input logic [3:0] head, input bit busy);
    if (!busy) return {IDLE_BIT, 3'b000, 1'b0, 1'b1, 1'b1};
    return {head, 1'b1, 1'b0, 1'b0};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cycle_gap0", {if0.dout, if0.dout_vld, if0.sof, if0.eof, if0.busy, if0.start_rdy, (st0 == ST_IDLE)},
          expect_vec((exp_q0.size() != 0) ? exp_q0[0] : 4'h0, exp_q0.size() != 0));
      chk("cycle_gap2", {if2.dout, if2.dout_vld, if2.sof, if2.eof, if2.busy, if2.start_rdy, (st2 == ST_IDLE)},
          expect_vec((exp_q2.size() != 0) ? exp_q2[0] : 4'h0, exp_q2.size() != 0));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle();
    int k;
    k = 0;
    while ((exp_q0.size() != 0 || exp_q2.size() != 0 || !if0.start_rdy || !if2.start_rdy) && k < 300) begin
      @(posedge clk); #1;
      k++;
    end
    if (k >= 300) begin
      n_vec++;
      n_err++;
      $display("FAIL wait_idle: still busy after %0d cycles", k);
    end
  endtask

  // Returns one time step into cycle 1 (the cycle after the handshake edge).
  task automatic issue(input logic [PAT_W-1:0] p, input logic [CNT_W-1:0] r);
    wait_idle();
    start_vld = 1'b1;
    pattern   = p;
    rep       = r;
    @(posedge clk); #1;
    start_vld = 1'b0;
    pattern   = ~p;      // later pattern changes must be ignored
    rep       = 8'd5;
  endtask

  task automatic capture(input int n, input int sel,
                         output logic [31:0] d, output logic [31:0] v, output logic [31:0] s,
                         output logic [31:0] e, output logic [31:0] b, output logic [31:0] r);
    d = '0; v = '0; s = '0; e = '0; b = '0; r = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      d = {d[30:0], (sel == 0) ? if0.dout      : if2.dout};
      v = {v[30:0], (sel == 0) ? if0.dout_vld  : if2.dout_vld};
      s = {s[30:0], (sel == 0) ? if0.sof       : if2.sof};
      e = {e[30:0], (sel == 0) ? if0.eof       : if2.eof};
      b = {b[30:0], (sel == 0) ? if0.busy      : if2.busy};
      r = {r[30:0], (sel == 0) ? if0.start_rdy : if2.start_rdy};
    end
  endtask

  // ---------------- stimulus ----------------
  logic [31:0] d, v, s, e, b, r;
  logic [7:0]  stream;
  int          hits;

  initial begin
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_gap0", {if0.dout, if0.dout_vld, if0.sof, if0.eof, if0.busy, if0.start_rdy}, 6'b000001);
    chk("reset_gap2", {if2.dout, if2.dout_vld, if2.sof, if2.eof, if2.busy, if2.start_rdy}, 6'b000001);
    cmp_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 1: single 1011
    issue(4'b1011, 8'd1);
    capture(5, 0, d, v, s, e, b, r);
    chk("t1_dout", d, 32'b10110);
    chk("t1_sof",  s, 32'b10000);
    chk("t1_eof",  e, 32'b00010);
    chk("t1_rdy",  r, 32'b00001);

    // 2: two seamless repetitions
    issue(4'b1011, 8'd2);
    capture(9, 0, d, v, s, e, b, r);
    chk("t2_dout", d, 32'b101110110);
    chk("t2_vld",  v, 32'b111111110);
    chk("t2_sof",  s, 32'b100010000);
    chk("t2_eof",  e, 32'b000000010);
    stream = d[8:1];
    hits = 0;
    for (int i = 0; i < 5; i++) if (stream[7-i -: 4] == 4'b1011) hits++;
    chk("t2_hits", hits, 2);

    // 3: GAP=2 build, three repetitions
    issue(4'b1011, 8'd3);
    capture(17, 2, d, v, s, e, b, r);
    chk("t3_dout", d, 32'b1011_00_1011_00_1011_0);
    chk("t3_vld",  v, 32'b1111_00_1111_00_1111_0);
    chk("t3_sof",  s, 32'b1000_00_1000_00_1000_0);
    chk("t3_eof",  e, 32'b0000_00_0000_00_0001_0);
    chk("t3_busy", b, 32'b1111_11_1111_11_1111_0);

    // 4: rep=0 behaves as one repetition
    issue(4'b0110, 8'd0);
    capture(5, 0, d, v, s, e, b, r);
    chk("t4_dout", d, 32'b01100);
    chk("t4_eof",  e, 32'b00010);
    chk("t4_busy", b, 32'b11110);

    // 5a: abort on cycle 3
    issue(4'b1011, 8'd1);
    @(posedge clk); #1;          // cycle 2
    @(posedge clk); #1;          // cycle 3
    abort = 1'b1;
    @(posedge clk); #1;          // cycle 4
    abort = 1'b0;
    capture(4, 0, d, v, s, e, b, r);
    chk("t5_dout", d, 32'b0000);
    chk("t5_busy", b, 32'b0000);
    chk("t5_eof",  e, 32'b0000);
    chk("t5_rdy",  r, 32'b1111);

    // 5b: abort together with start_vld in IDLE
    wait_idle();
    start_vld = 1'b1; abort = 1'b1; pattern = 4'b1011; rep = 8'd1;
    @(posedge clk); #1;
    start_vld = 1'b0; abort = 1'b0;
    capture(4, 0, d, v, s, e, b, r);
    chk("t5b_busy", b, 32'b0000);
    chk("t5b_vld",  v, 32'b0000);

    // 6: reset mid-transfer, then start_vld held high
    issue(4'b1011, 8'd3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    start_vld = 1'b1; pattern = 4'b1011; rep = 8'd1;
    #1;
    chk("t6_rst_gap0", {if0.dout, if0.dout_vld, if0.sof, if0.eof, if0.busy, if0.start_rdy}, 6'b000001);
    chk("t6_rst_gap2", {if2.dout, if2.dout_vld, if2.sof, if2.eof, if2.busy, if2.start_rdy}, 6'b000001);
    @(posedge clk);
    @(posedge clk); #3;
    rst_n = 1'b1;
    capture(11, 0, d, v, s, e, b, r);
    start_vld = 1'b0;
    chk("t6_busy", b, 32'b0_1111_0_1111_0);
    chk("t6_sof",  s, 32'b0_1000_0_1000_0);

    wait_idle();
    repeat (3) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
